// File: rtl/de_input_conditioner.sv
// -----------------------------------------------------------------------------
// de_input_conditioner
//
// Conditions the raw DE-board pushbuttons (KEY) and slide switches (SW) before
// they reach lab logic. Every bit passes through a 2-flop synchronizer. It then
// goes through its own debounce FSM, which accepts a new level only after the
// synchronized sample has differed from the current level for DEBOUNCE_CYCLES
// consecutive clocks. Accepted changes also produce a registered one-cycle
// pulse. The pulse coincides with the first cycle of the new level.
//
// Parameters
//   N_KEY            number of pushbuttons (raw pins are active-low)
//   N_SW             number of slide switches
//   DEBOUNCE_CYCLES  stable cycles needed to accept a change (>= 1)
//   CNT_W            counter width, 2**CNT_W must exceed DEBOUNCE_CYCLES
//
// Ports
//   CLOCK_50     in   board clock, all flops on the rising edge
//   resetn       in   asynchronous active-low reset
//   KEY          in   raw pushbuttons, 0 = pressed, asynchronous
//   SW           in   raw switches, 1 = up, asynchronous
//   key_down     out  debounced key level, 1 = pressed
//   key_press    out  one-cycle pulse when key_down rises
//   key_release  out  one-cycle pulse when key_down falls
//   sw_level     out  debounced switch level
//   sw_changed   out  one-cycle pulse on any sw_level transition
//
// The design has no valid/ready handshakes. All outputs are plain levels or
// single-cycle pulses that are valid on every clock.
// -----------------------------------------------------------------------------
module de_input_conditioner #(
  parameter int N_KEY           = 4,
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [N_KEY-1:0] KEY,
  input  logic [N_SW-1:0]  SW,
  output logic [N_KEY-1:0] key_down,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_changed
);

  // All debounced bits share one vector: keys in the low bits, switches above.
  localparam int N = N_KEY + N_SW;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

  // ---------------------------------------------------------------------------
  // Synchronizers. The reset values match the released state of each input:
  // raw 1 for keys and 0 for switches. With these values no change is seen
  // when reset is released while the inputs are idle.
  // ---------------------------------------------------------------------------
  logic [N_KEY-1:0] key_s1, key_s2;
  logic [N_SW-1:0]  sw_s1, sw_s2;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
    end
  end

  // Keys are inverted here, so every debounced bit reads 1 = active.
  logic [N-1:0] sample;
  assign sample = {sw_s2, ~key_s2};

  // ---------------------------------------------------------------------------
  // Per-bit debounce FSMs: the state register.
  // ---------------------------------------------------------------------------
  db_state_e        state_q [N];
  db_state_e        state_d [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];
  logic [N-1:0]     level_q, level_d;
  logic [N-1:0]     pulse_q, pulse_d;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce FSMs: next state. The counter holds the number of
  // consecutive mismatching samples seen so far. The sample that reaches
  // DEBOUNCE_CYCLES is accepted, so the counter never exceeds
  // DEBOUNCE_CYCLES-1.
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (state_q[i] == ST_STABLE) begin
        cnt_d[i] = '0;
        if (sample[i] != level_q[i]) begin
          // With a one-cycle window the first mismatch is already the
          // qualifying one, so it is accepted immediately.
          if (DEBOUNCE_CYCLES == 1) begin
            level_d[i] = sample[i];
            pulse_d[i] = 1'b1;
          end else begin
            state_d[i] = ST_PENDING;
            cnt_d[i]   = CNT_ONE;
          end
        end
      end else begin
        if (sample[i] == level_q[i]) begin
          // Bounce: the input returned before qualifying. Drop it silently.
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sample[i];
          pulse_d[i] = 1'b1;
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. A pulse is registered together with the level it announces, so
  // the new level gives the direction of a key pulse. For that reason press
  // and release can never be high together on one bit.
  // ---------------------------------------------------------------------------
  assign key_down    = level_q[N_KEY-1:0];
  assign key_press   = pulse_q[N_KEY-1:0] & level_q[N_KEY-1:0];
  assign key_release = pulse_q[N_KEY-1:0] & ~level_q[N_KEY-1:0];
  assign sw_level    = level_q[N-1:N_KEY];
  assign sw_changed  = pulse_q[N-1:N_KEY];

endmodule

// File: tb/tb_de_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_de_input_conditioner
//
// Directed bench for de_input_conditioner with DEBOUNCE_CYCLES = 4. The
// expected latency from a raw edge to the output is 2 + 4 = 6 clock edges.
// Inputs change 1 time unit after a rising edge. Outputs are sampled 1 time
// unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_de_input_conditioner;

  localparam int N_KEY = 4;
  localparam int N_SW  = 10;
  localparam int DB    = 4;
  localparam int CW    = 4;

  logic             CLOCK_50;
  logic             resetn;
  logic [N_KEY-1:0] KEY;
  logic [N_SW-1:0]  SW;
  logic [N_KEY-1:0] key_down, key_press, key_release;
  logic [N_SW-1:0]  sw_level, sw_changed;

  int n_checks = 0;
  int n_fail   = 0;

  de_input_conditioner #(
    .N_KEY(N_KEY), .N_SW(N_SW), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .KEY        (KEY),
    .SW         (SW),
    .key_down   (key_down),
    .key_press  (key_press),
    .key_release(key_release),
    .sw_level   (sw_level),
    .sw_changed (sw_changed)
  );

  // clock / reset
  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // driver helpers
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    KEY    = 4'hF;
    SW     = '0;
    step(3);
    resetn = 1'b1;

    // Idle after reset: every output stays 0.
    for (int c = 0; c < 20; c++) begin
      step(1);
      check("idle_all", {key_down, key_press, key_release, sw_level, sw_changed}, 32'h0);
    end

    // KEY[0] press and release, 6-edge latency each way.
    KEY[0] = 1'b0;
    step(5);
    check("k0_down_early", key_down, 4'b0000);
    check("k0_press_early", key_press, 4'b0000);
    step(1);
    check("k0_down", key_down, 4'b0001);
    check("k0_press", key_press, 4'b0001);
    check("k0_no_release", key_release, 4'b0000);
    step(1);
    check("k0_press_gone", key_press, 4'b0000);
    check("k0_down_hold", key_down, 4'b0001);
    KEY[0] = 1'b1;
    step(5);
    check("k0_down_before_rel", key_down, 4'b0001);
    check("k0_rel_early", key_release, 4'b0000);
    step(1);
    check("k0_up", key_down, 4'b0000);
    check("k0_release", key_release, 4'b0001);
    check("k0_no_press", key_press, 4'b0000);
    step(1);
    check("k0_release_gone", key_release, 4'b0000);

    // KEY[1] bounce of 3 cycles is rejected.
    KEY[1] = 1'b0;
    step(3);
    KEY[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1);
      check("k1_bounce3", {key_down, key_press, key_release}, 12'h0);
    end

    // KEY[1] bounce of 4 cycles is accepted. The release qualifies 4 edges
    // later.
    KEY[1] = 1'b0;
    step(4);
    KEY[1] = 1'b1;
    step(1);
    check("k1_b4_early", key_down, 4'b0000);
    step(1);
    check("k1_b4_down", key_down, 4'b0010);
    check("k1_b4_press", key_press, 4'b0010);
    step(3);
    check("k1_b4_still_down", key_down, 4'b0010);
    check("k1_b4_no_pulse", {key_press, key_release}, 8'h00);
    step(1);
    check("k1_b4_up", key_down, 4'b0000);
    check("k1_b4_release", key_release, 4'b0010);
    step(1);
    check("k1_b4_release_gone", key_release, 4'b0000);

    // Multi-bit switch change in one cycle.
    SW = 10'h3A5;
    step(5);
    check("sw_level_early", sw_level, 10'h000);
    check("sw_changed_early", sw_changed, 10'h000);
    step(1);
    check("sw_level", sw_level, 10'h3A5);
    check("sw_changed", sw_changed, 10'h3A5);
    step(1);
    check("sw_changed_gone", sw_changed, 10'h000);
    check("sw_level_hold", sw_level, 10'h3A5);

    // KEY[2] pressed, with reset in the middle of the debounce.
    KEY[2] = 1'b0;
    step(4);
    resetn = 1'b0;
    step(2);
    check("rst_key_down", key_down, 4'b0000);
    check("rst_key_press", key_press, 4'b0000);
    check("rst_sw_level", sw_level, 10'h000);
    resetn = 1'b1;
    step(5);
    check("k2_after_rst_early", {key_down, key_press}, 8'h00);
    check("sw_after_rst_early", sw_level, 10'h000);
    step(1);
    check("k2_after_rst_down", key_down, 4'b0100);
    check("k2_after_rst_press", key_press, 4'b0100);
    check("sw_after_rst_level", sw_level, 10'h3A5);
    check("sw_after_rst_changed", sw_changed, 10'h3A5);
    step(1);
    check("k2_after_rst_press_gone", key_press, 4'b0000);
    check("sw_after_rst_changed_gone", sw_changed, 10'h000);

    // Release KEY[2] and return the switches to 0.
    KEY = 4'hF;
    SW  = '0;
    step(6);
    check("k2_release", key_release, 4'b0100);
    check("sw_back_changed", sw_changed, 10'h3A5);
    check("sw_back_level", sw_level, 10'h000);
    step(1);

    // KEY[0] and KEY[3] are pressed on the same edge.
    KEY = 4'b0110;
    step(5);
    check("k03_press_early", key_press, 4'b0000);
    step(1);
    check("k03_press", key_press, 4'b1001);
    check("k03_down", key_down, 4'b1001);
    step(1);
    check("k03_press_gone", key_press, 4'b0000);
    KEY = 4'hF;
    step(6);
    check("k03_release", key_release, 4'b1001);
    check("k03_up", key_down, 4'b0000);
    step(1);
    check("k03_release_gone", key_release, 4'b0000);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
